// File: rtl/branch_predict_if.sv
// branch_predict_if: pipeline-side bus of the branch predict unit (IF lookup, MEM resolution, flushes, perf counters).
interface branch_predict_if #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
);
  logic [XLEN-1:0]   if_pc;
  logic              mem_valid;
  logic [XLEN-1:0]   mem_pc;
  logic [2:0]        mem_npcop;
  logic              mem_zero;
  logic [XLEN-1:0]   mem_immout;
  logic [XLEN-1:0]   mem_aluout;
  logic              mem_pred_taken;
  logic [XLEN-1:0]   mem_pred_target;
  logic              if_pred_taken;
  logic [XLEN-1:0]   if_pred_target;
  logic [XLEN-1:0]   npc;
  logic              if_flush;
  logic              id_flush;
  logic              ex_flush;
  logic [PERF_W-1:0] branch_cnt;
  logic [PERF_W-1:0] mispred_cnt;

  modport master (
    output if_pc, mem_valid, mem_pc, mem_npcop, mem_zero, mem_immout, mem_aluout,
           mem_pred_taken, mem_pred_target,
    input  if_pred_taken, if_pred_target, npc, if_flush, id_flush, ex_flush,
           branch_cnt, mispred_cnt
  );

  modport slave (
    input  if_pc, mem_valid, mem_pc, mem_npcop, mem_zero, mem_immout, mem_aluout,
           mem_pred_taken, mem_pred_target,
    output if_pred_taken, if_pred_target, npc, if_flush, id_flush, ex_flush,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with saturating counters; predicts next PC in IF, resolves in MEM, flushes only on mispredict.
module branch_predict_unit #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int PERF_W   = 32
) (
  input logic              clk,
  input logic              rstn,
  branch_predict_if.slave  bus
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;
  localparam logic [CTR_BITS-1:0] CMAX = '1;
  localparam logic [CTR_BITS-1:0] CWT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CWNT = CWT - CTR_BITS'(1);

  logic [ENTRIES-1:0]  valid_q, jmp_q;
  logic [TAGW-1:0]     tag_q [ENTRIES];
  logic [XLEN-1:0]     tgt_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [PERF_W-1:0]   branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

  logic [IDXW-1:0]     if_idx, mem_idx;
  logic                if_hit, mem_hit, is_br, is_ctl, act_taken, mispred, wr_en, jmp_d;
  logic [XLEN-1:0]     act_tgt, tgt_d;
  logic [CTR_BITS-1:0] ctr_cur, ctr_d;

  always_comb begin
    if_idx = bus.if_pc[IDXW+1:2];
    if_hit = valid_q[if_idx] && tag_q[if_idx] == bus.if_pc[XLEN-1:IDXW+2];
    bus.if_pred_taken  = if_hit && (jmp_q[if_idx] || ctr_q[if_idx][CTR_BITS-1]);
    bus.if_pred_target = if_hit ? tgt_q[if_idx] : bus.if_pc + XLEN'(4);
    is_br     = bus.mem_npcop == 3'b001;
    is_ctl    = bus.mem_valid && (is_br || bus.mem_npcop == 3'b010 || bus.mem_npcop == 3'b100);
    act_taken = !is_br || bus.mem_zero;
    act_tgt   = bus.mem_npcop == 3'b100 ? bus.mem_aluout : bus.mem_pc + bus.mem_immout;
    mispred   = is_ctl && (act_taken != bus.mem_pred_taken ||
                (act_taken && bus.mem_pred_taken && act_tgt != bus.mem_pred_target));
    bus.npc = mispred ? (act_taken ? act_tgt : bus.mem_pc + XLEN'(4)) :
              bus.if_pred_taken ? bus.if_pred_target : bus.if_pc + XLEN'(4);
    bus.if_flush = mispred;
    bus.id_flush = mispred;
    bus.ex_flush = mispred;
    // Update path: the MEM instruction's own entry, independent of the IF lookup (no bypass).
    mem_idx = bus.mem_pc[IDXW+1:2];
    mem_hit = valid_q[mem_idx] && tag_q[mem_idx] == bus.mem_pc[XLEN-1:IDXW+2];
    ctr_cur = ctr_q[mem_idx];
    wr_en   = is_ctl && (mem_hit || act_taken);
    jmp_d   = !is_br || (mem_hit && jmp_q[mem_idx]);
    tgt_d   = act_taken ? act_tgt : tgt_q[mem_idx];
    ctr_d   = !is_br ? CMAX : !mem_hit ? CWT :
              act_taken ? (ctr_cur == CMAX ? ctr_cur : ctr_cur + CTR_BITS'(1)) :
              (ctr_cur == '0 ? ctr_cur : ctr_cur - CTR_BITS'(1));
    branch_cnt_d  = branch_cnt_q + PERF_W'(is_ctl);
    mispred_cnt_d = mispred_cnt_q + PERF_W'(mispred);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q       <= '0;
      jmp_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CWNT;
      end
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (wr_en) begin
        valid_q[mem_idx] <= 1'b1;
        jmp_q[mem_idx]   <= jmp_d;
        tag_q[mem_idx]   <= bus.mem_pc[XLEN-1:IDXW+2];
        tgt_q[mem_idx]   <= tgt_d;
        ctr_q[mem_idx]   <= ctr_d;
      end
    end
  end

  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed and randomized checks of the branch predict unit against a PC-keyed BTB model.
module tb_branch_predict_unit;
  localparam int E = 16;

  logic clk = 1'b0;
  logic rstn;
  int checks = 0;
  int errors = 0;

  branch_predict_if #(.XLEN(32), .PERF_W(4)) bus ();
  branch_predict_unit #(.XLEN(32), .ENTRIES(E), .CTR_BITS(2), .PERF_W(4)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: each slot remembers the full word address of its owner plus target/jump/counter.
  bit          mv [E];
  logic [31:0] mk [E];
  logic [31:0] mt [E];
  bit          mj [E];
  int          mcr [E];
  int          bcm, mcm;

  function automatic void mdl_reset();
    for (int i = 0; i < E; i++) begin
      mv[i] = 0; mk[i] = 0; mt[i] = 0; mj[i] = 0; mcr[i] = 1;
    end
    bcm = 0; mcm = 0;
  endfunction

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % E);
  endfunction

  function automatic void mdl_predict(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int  i = slot(pc);
    bit  h = mv[i] && mk[i] == (pc >> 2);
    t  = h && (mj[i] || mcr[i] >= 2);
    tg = h ? mt[i] : pc + 4;
  endfunction

  function automatic void mdl_resolve(output bit ctl, output bit tk, output bit mis, output logic [31:0] tg);
    logic [2:0] op = bus.mem_npcop;
    ctl = bus.mem_valid && (op == 1 || op == 2 || op == 4);
    tk  = op != 1 || bus.mem_zero;
    tg  = op == 4 ? bus.mem_aluout : bus.mem_pc + bus.mem_immout;
    mis = ctl && (tk != bus.mem_pred_taken || (tk && bus.mem_pred_taken && tg != bus.mem_pred_target));
  endfunction

  function automatic void mdl_update();
    bit ctl, tk, mis, h;
    logic [31:0] tg;
    int i;
    mdl_resolve(ctl, tk, mis, tg);
    if (!ctl) return;
    bcm = (bcm + 1) % 16;
    if (mis) mcm = (mcm + 1) % 16;
    i = slot(bus.mem_pc);
    h = mv[i] && mk[i] == (bus.mem_pc >> 2);
    if (h && bus.mem_npcop == 1) begin
      mcr[i] = tk ? (mcr[i] < 3 ? mcr[i] + 1 : 3) : (mcr[i] > 0 ? mcr[i] - 1 : 0);
      if (tk) mt[i] = tg;
    end else if (h) begin
      mj[i] = 1; mcr[i] = 3; mt[i] = tg;
    end else if (tk) begin
      mv[i] = 1; mk[i] = bus.mem_pc >> 2; mt[i] = tg;
      mj[i] = bus.mem_npcop != 1;
      mcr[i] = bus.mem_npcop != 1 ? 3 : 2;
    end
  endfunction

  task automatic drive(input logic [31:0] ipc, input logic v, input logic [31:0] pc, input logic [2:0] op,
                       input logic z, input logic [31:0] imm, input logic [31:0] alu,
                       input logic pt, input logic [31:0] ptg);
    bus.if_pc = ipc; bus.mem_valid = v; bus.mem_pc = pc; bus.mem_npcop = op; bus.mem_zero = z;
    bus.mem_immout = imm; bus.mem_aluout = alu; bus.mem_pred_taken = pt; bus.mem_pred_target = ptg;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    mdl_reset();
    @(negedge clk);
    drive(32'h100, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (bus.npc !== 32'h104) begin errors++; $display("FAIL reset_npc got %h exp %h", bus.npc, 32'h104); end
    checks++;
    if (bus.if_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got %b exp 0", bus.if_pred_taken); end
    checks++;
    if ({bus.if_flush, bus.id_flush, bus.ex_flush} !== 3'b000)
      begin errors++; $display("FAIL reset_flush got %b exp 000", {bus.if_flush, bus.id_flush, bus.ex_flush}); end
    checks++;
    if (bus.branch_cnt !== 4'd0 || bus.mispred_cnt !== 4'd0)
      begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", bus.branch_cnt, bus.mispred_cnt); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct packed {
    logic [31:0] ipc; logic v; logic [31:0] pc; logic [2:0] op; logic z;
    logic [31:0] imm; logic [31:0] alu; logic pt; logic [31:0] ptg;
    logic [31:0] e_npc; logic e_fl; logic e_pt; logic [31:0] e_tgt; logic [3:0] e_bc; logic [3:0] e_mc;
  } step_t;

  task automatic test_btb_sequence();
    step_t tbl [15] = '{
      '{32'h100, 1'b1, 32'h200, 3'd1, 1'b1, 32'h40, 32'h0,   1'b0, 32'h204, 32'h240, 1'b1, 1'b0, 32'h104, 4'd1, 4'd1},
      '{32'h200, 1'b1, 32'h200, 3'd1, 1'b1, 32'h40, 32'h0,   1'b1, 32'h240, 32'h240, 1'b0, 1'b1, 32'h240, 4'd2, 4'd1},
      '{32'h200, 1'b1, 32'h200, 3'd1, 1'b0, 32'h40, 32'h0,   1'b1, 32'h240, 32'h204, 1'b1, 1'b1, 32'h240, 4'd3, 4'd2},
      '{32'h200, 1'b1, 32'h200, 3'd1, 1'b0, 32'h40, 32'h0,   1'b1, 32'h240, 32'h204, 1'b1, 1'b1, 32'h240, 4'd4, 4'd3},
      '{32'h200, 1'b0, 32'h0,   3'd0, 1'b0, 32'h0,  32'h0,   1'b0, 32'h0,   32'h204, 1'b0, 1'b0, 32'h240, 4'd4, 4'd3},
      '{32'h300, 1'b1, 32'h300, 3'd4, 1'b0, 32'h0,  32'h500, 1'b0, 32'h304, 32'h500, 1'b1, 1'b0, 32'h304, 4'd5, 4'd4},
      '{32'h300, 1'b1, 32'h300, 3'd4, 1'b0, 32'h0,  32'h600, 1'b1, 32'h500, 32'h600, 1'b1, 1'b1, 32'h500, 4'd6, 4'd5},
      '{32'h300, 1'b0, 32'h0,   3'd0, 1'b0, 32'h0,  32'h0,   1'b0, 32'h0,   32'h600, 1'b0, 1'b1, 32'h600, 4'd6, 4'd5},
      '{32'h240, 1'b1, 32'h240, 3'd1, 1'b1, 32'h40, 32'h0,   1'b0, 32'h244, 32'h280, 1'b1, 1'b0, 32'h244, 4'd7, 4'd6},
      '{32'h200, 1'b1, 32'h200, 3'd1, 1'b1, 32'h40, 32'h0,   1'b0, 32'h204, 32'h240, 1'b1, 1'b0, 32'h204, 4'd8, 4'd7},
      '{32'h240, 1'b0, 32'h0,   3'd0, 1'b0, 32'h0,  32'h0,   1'b0, 32'h0,   32'h244, 1'b0, 1'b0, 32'h244, 4'd8, 4'd7},
      '{32'h200, 1'b0, 32'h0,   3'd0, 1'b0, 32'h0,  32'h0,   1'b0, 32'h0,   32'h240, 1'b0, 1'b1, 32'h240, 4'd8, 4'd7},
      '{32'h100, 1'b1, 32'h200, 3'd3, 1'b1, 32'h40, 32'h0,   1'b1, 32'h240, 32'h104, 1'b0, 1'b0, 32'h104, 4'd8, 4'd7},
      '{32'h100, 1'b0, 32'h700, 3'd1, 1'b1, 32'h40, 32'h0,   1'b0, 32'h704, 32'h104, 1'b0, 1'b0, 32'h104, 4'd8, 4'd7},
      '{32'h700, 1'b0, 32'h0,   3'd0, 1'b0, 32'h0,  32'h0,   1'b0, 32'h0,   32'h704, 1'b0, 1'b0, 32'h704, 4'd8, 4'd7}
    };
    for (int s = 0; s < 15; s++) begin
      drive(tbl[s].ipc, tbl[s].v, tbl[s].pc, tbl[s].op, tbl[s].z, tbl[s].imm, tbl[s].alu, tbl[s].pt, tbl[s].ptg);
      checks++;
      if (bus.npc !== tbl[s].e_npc) begin errors++; $display("FAIL seq%0d_npc got %h exp %h", s, bus.npc, tbl[s].e_npc); end
      checks++;
      if ({bus.if_flush, bus.id_flush, bus.ex_flush} !== {3{tbl[s].e_fl}})
        begin errors++; $display("FAIL seq%0d_flush got %b exp %b", s, {bus.if_flush, bus.id_flush, bus.ex_flush}, {3{tbl[s].e_fl}}); end
      checks++;
      if (bus.if_pred_taken !== tbl[s].e_pt || bus.if_pred_target !== tbl[s].e_tgt)
        begin errors++; $display("FAIL seq%0d_pred got %b/%h exp %b/%h", s, bus.if_pred_taken, bus.if_pred_target, tbl[s].e_pt, tbl[s].e_tgt); end
      tick();
      checks++;
      if (bus.branch_cnt !== tbl[s].e_bc || bus.mispred_cnt !== tbl[s].e_mc)
        begin errors++; $display("FAIL seq%0d_cnt got %0d/%0d exp %0d/%0d", s, bus.branch_cnt, bus.mispred_cnt, tbl[s].e_bc, tbl[s].e_mc); end
    end
  endtask

  task automatic test_reset_midrun();
    drive(32'h200, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (bus.if_pred_taken !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", bus.if_pred_taken); end
    rstn = 1'b0;
    #1;
    mdl_reset();
    checks++;
    if (bus.if_pred_taken !== 1'b0 || bus.npc !== 32'h204)
      begin errors++; $display("FAIL midrst_btb got %b/%h exp 0/00000204", bus.if_pred_taken, bus.npc); end
    checks++;
    if (bus.branch_cnt !== 4'd0 || bus.mispred_cnt !== 4'd0)
      begin errors++; $display("FAIL midrst_cnt got %0d/%0d exp 0/0", bus.branch_cnt, bus.mispred_cnt); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_counter_wrap();
    for (int n = 1; n <= 16; n++) begin
      drive(32'h100, 1'b1, 32'h800, 3'd1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h804);
      tick();
      if (n >= 15) begin
        checks++;
        if (bus.branch_cnt !== 4'(n % 16) || bus.mispred_cnt !== 4'd0)
          begin errors++; $display("FAIL wrap%0d_cnt got %0d/%0d exp %0d/0", n, bus.branch_cnt, bus.mispred_cnt, n % 16); end
      end
    end
  endtask

  function automatic logic [31:0] pick();
    return 32'h1000 + 32'(4 * $urandom_range(0, 39));
  endfunction

  task automatic test_random();
    logic [2:0] ops [8] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd4, 3'd3, 3'd1};
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ipc, mpc, imm, alu, ptg, etg, tg, enpc;
      logic [2:0] op;
      bit v, z, pt, ept, ctl, tk, mis;
      ipc = pick(); mpc = pick(); alu = pick();
      op  = ops[$urandom_range(0, 7)];
      v   = $urandom_range(0, 3) != 0;
      z   = $urandom_range(0, 1) == 1;
      imm = 32'(4 * $urandom_range(1, 16));
      if ($urandom_range(0, 3) != 0) mdl_predict(mpc, pt, ptg);
      else begin pt = $urandom_range(0, 1) == 1; ptg = pick(); end
      drive(ipc, v, mpc, op, z, imm, alu, pt, ptg);
      mdl_predict(ipc, ept, etg);
      mdl_resolve(ctl, tk, mis, tg);
      enpc = mis ? (tk ? tg : mpc + 4) : ept ? etg : ipc + 4;
      checks++;
      if (bus.if_pred_taken !== ept || bus.if_pred_target !== etg)
        begin errors++; $display("FAIL rnd%0d_pred got %b/%h exp %b/%h", n, bus.if_pred_taken, bus.if_pred_target, ept, etg); end
      checks++;
      if (bus.npc !== enpc) begin errors++; $display("FAIL rnd%0d_npc got %h exp %h", n, bus.npc, enpc); end
      checks++;
      if ({bus.if_flush, bus.id_flush, bus.ex_flush} !== {3{mis}})
        begin errors++; $display("FAIL rnd%0d_flush got %b exp %b", n, {bus.if_flush, bus.id_flush, bus.ex_flush}, {3{mis}}); end
      tick();
      checks++;
      if (bus.branch_cnt !== 4'(bcm) || bus.mispred_cnt !== 4'(mcm))
        begin errors++; $display("FAIL rnd%0d_cnt got %0d/%0d exp %0d/%0d", n, bus.branch_cnt, bus.mispred_cnt, bcm, mcm); end
    end
  endtask

  initial begin
    test_reset();
    test_btb_sequence();
    test_reset_midrun();
    test_counter_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised next-generation next-PC/flush unit for the 5-stage RISC-V pipeline.
- Adds a direct-mapped branch target buffer (BTB) with saturating direction counters. IF gets a predicted next PC every cycle.
- Control transfers resolve in MEM. IF/ID/EX are flushed only on a misprediction, not on every taken transfer.
- Keeps branch and misprediction performance counters.

Parameters:
- XLEN, 32, datapath/PC width.
- ENTRIES, 16, number of BTB entries; power of 2, minimum 2. IDXW = log2(ENTRIES).
- CTR_BITS, 2, width of each direction counter; range 1..4.
- PERF_W, 32, width of the performance counters.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rstn, input, 1, asynchronous active-low reset.
- if_pc, input, XLEN, PC of the instruction currently in IF.
- mem_valid, input, 1, MEM stage holds a valid, non-flushed instruction.
- mem_pc, input, XLEN, PC of the MEM instruction.
- mem_npcop, input, 3, control op: 000 plus4, 001 branch, 010 jal, 100 jalr.
- mem_zero, input, 1, branch condition result.
- mem_immout, input, XLEN, branch/jal offset.
- mem_aluout, input, XLEN, jalr target.
- mem_pred_taken, input, 1, prediction made in IF for this instruction, piped down to MEM.
- mem_pred_target, input, XLEN, predicted target, piped down to MEM.
- if_pred_taken, output, 1, current IF prediction; the pipeline carries it to MEM.
- if_pred_target, output, XLEN, current IF predicted target.
- npc, output, XLEN, next PC to load into the PC register.
- if_flush, output, 1, flush IF/ID.
- id_flush, output, 1, flush ID/EX.
- ex_flush, output, 1, flush EX/MEM.
- branch_cnt, output, PERF_W, number of resolved control instructions.
- mispred_cnt, output, PERF_W, number of mispredictions.

Behaviour:
- BTB entry fields: valid, tag[XLEN-IDXW-2], target[XLEN], jmp, ctr[CTR_BITS].
- Index = pc[IDXW+1:2]; tag = pc[XLEN-1:IDXW+2].
- Lookup is combinational on if_pc. hit = valid && tag match.
  - if_pred_taken = hit && (jmp || ctr MSB).
  - if_pred_target = entry target when hit, else if_pc+4.
- Resolution is combinational while mem_valid=1 and mem_npcop ∈ {001, 010, 100}:
  - actual_taken = (001 && mem_zero) || 010 || 100.
  - actual_target = mem_pc+mem_immout for 001/010; mem_aluout for 100.
  - mispredict = actual_taken != mem_pred_taken, or (both taken && actual_target != mem_pred_target).
- Any other mem_npcop, or mem_valid=0: not a control instruction; mispredict=0; no update.
- npc priority:
  - mispredict: actual_target if actual_taken, else mem_pc+4;
  - else if_pred_taken: if_pred_target;
  - else if_pc+4.
- if_flush = id_flush = ex_flush = mispredict, same cycle, combinational.
- BTB update at the clock edge, only for a resolved control instruction:
  - Hit, branch: ctr saturating +1 if taken, -1 if not taken. Target rewritten with actual_target when taken.
  - Hit, jal/jalr: jmp=1, ctr=max, target=actual_target.
  - Miss, taken: allocate, overwriting whatever occupies the index. valid=1, new tag and target, jmp = (op≠001), ctr = max for jumps, else 1<<(CTR_BITS-1) (weakly taken).
  - Miss, not taken: no allocation.
- Same-cycle lookup and update on the same index: lookup returns pre-update contents; no bypass.
- Counters:
  - branch_cnt += 1 per resolved control instruction.
  - mispred_cnt += 1 per mispredict.
  - Both wrap modulo 2^PERF_W.
- Reset, asynchronous, also mid-operation:
  - all valid=0; ctr = (1<<(CTR_BITS-1))-1 (weakly not-taken); jmp=0; targets and tags 0; perf counters 0.
  - Combinational outputs then follow the rules above: with an empty BTB and mem_valid=0, if_pred_taken=0, npc=if_pc+4, flushes=0.

Test Plan:
- Reset, if_pc=0x100, mem_valid=0 -> npc=0x104, if_pred_taken=0, all flushes 0, both counters 0.
- Cold taken branch: mem_pc=0x200, op=001, zero=1, imm=0x40, pred_taken=0 -> flushes=1, npc=0x240. Next cycle if_pc=0x200 -> if_pred_taken=1, target=0x240; branch_cnt=1, mispred_cnt=1.
- Same branch resolved taken again with mem_pred_taken=1, target 0x240 -> flushes=0, ctr saturates at 3, npc follows the IF prediction.
- Not-taken from ctr=2 with pred_taken=1 -> flush, npc=0x204, ctr=1. Next lookup of 0x200 predicts not-taken.
- jalr at 0x300, aluout=0x500, then repeated with aluout=0x600 and pred_target=0x500 -> target mismatch mispredict, npc=0x600, BTB target becomes 0x600.
- Aliasing: 0x200 and 0x200+4*ENTRIES alternate taken -> each allocation evicts the other. Counter wrap with PERF_W=4 after 16 branches -> branch_cnt=0. rstn pulsed mid-run -> BTB empty immediately.
